// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: datapath widths,
// reset fetch address, the nop encoding and the fetch FSM states.
package ifu_pkg;

  localparam int CPU_WIDTH = 64;
  localparam int INS_WIDTH = 32;

  localparam logic [CPU_WIDTH-1:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [INS_WIDTH-1:0] NOP      = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DROP
  } ifu_state_t;

endpackage

// File: rtl/ifu_stdffre.sv
// Generic register with asynchronous active-low reset and load enable.
// Used for the pc and instruction registers of the fetch unit.
module stdffre #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: issues one fetch at a time, holds the returned word
// for the decoder, and discards responses made stale by a redirect.
module ifu
  import ifu_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = ifu_pkg::RESET_PC
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc,
  output logic                 imem_req_valid,
  input  logic                 imem_req_ready,
  output logic [CPU_WIDTH-1:0] imem_req_addr,
  input  logic                 imem_resp_valid,
  input  logic [INS_WIDTH-1:0] imem_resp_data,
  output logic                 ins_valid,
  input  logic                 ins_ready,
  output logic [INS_WIDTH-1:0] ins,
  output logic [CPU_WIDTH-1:0] pc
);

  ifu_state_t           state;
  ifu_state_t           state_nxt;
  logic                 ins_en;
  logic                 pc_en;
  logic                 consume;
  logic [CPU_WIDTH-1:0] pc_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    imem_req_valid = 1'b0;
    ins_valid      = 1'b0;
    ins_en         = 1'b0;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        imem_req_valid = 1'b1;
        // An accepted request under redirect still owes us a response to drop.
        if (imem_req_ready) state_nxt = redirect_valid ? DROP : WAIT;
      end
      WAIT: begin
        if (redirect_valid) begin
          state_nxt = imem_resp_valid ? REQ : DROP;
        end else if (imem_resp_valid) begin
          ins_en    = 1'b1;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        ins_valid = 1'b1;
        if (redirect_valid || ins_ready) state_nxt = REQ;
      end
      DROP: begin
        if (imem_resp_valid) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A redirect wins over sequential advance and cancels a same-cycle consume.
  assign consume = (state == HOLD) && ins_ready && !redirect_valid;
  assign pc_en   = redirect_valid || consume;
  assign pc_nxt  = redirect_valid ? (redirect_pc & ~64'h3) : (pc + 64'd4);

  stdffre #(
    .WIDTH    (CPU_WIDTH),
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (pc_en),
    .d    (pc_nxt),
    .q    (pc)
  );

  stdffre #(
    .WIDTH    (INS_WIDTH),
    .RESET_VAL(NOP)
  ) u_ins_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (ins_en),
    .d    (imem_resp_data),
    .q    (ins)
  );

  assign imem_req_addr = pc;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: a transaction-level pc/memory model checks every
// request and every presented instruction under directed and random stimulus.
module tb_ifu;
  import ifu_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 redirect_valid;
  logic [CPU_WIDTH-1:0] redirect_pc;
  logic                 imem_req_valid;
  logic                 imem_req_ready;
  logic [CPU_WIDTH-1:0] imem_req_addr;
  logic                 imem_resp_valid;
  logic [INS_WIDTH-1:0] imem_resp_data;
  logic                 ins_valid;
  logic                 ins_ready;
  logic [INS_WIDTH-1:0] ins;
  logic [CPU_WIDTH-1:0] pc;

  ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins            (ins),
    .pc             (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: architectural fetch pc, one outstanding memory read.
  logic [63:0] model_pc;
  bit          pend;
  int          pend_cnt;
  logic [63:0] pend_addr;
  int          n_cons;
  int          cycle;
  bit          last_acc;
  bit          hold_chk;
  logic [31:0] prev_ins;
  logic [63:0] prev_pc;
  logic [63:0] req_q[$];
  int          req_cyc[$];

  int rdy_pct, insrdy_pct, redir_pct, lat_lo, lat_hi;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    w = a[33:2];
    return (w * 32'h9e37_79b1) ^ a[63:32] ^ 32'h5a5a_0000;
  endfunction

  function automatic logic [63:0] rand_tgt();
    logic [63:0] t;
    t[31:0]  = 32'h8000_0000 | ($urandom & 32'h0000_0fff);
    t[63:32] = ($urandom_range(0, 7) == 0) ? 32'hffff_ffff : 32'h0;
    return t;
  endfunction

  // Entered at a negedge: check outputs, drive inputs for the coming edge,
  // advance the model, then wait for the following negedge.
  task automatic cyc(input bit frc, input logic [63:0] tgt);
    bit dlv, acc, cons;
    if (hold_chk) begin
      check("hold_valid", {63'b0, ins_valid}, 64'd1);
      check("hold_ins", {32'b0, ins}, {32'b0, prev_ins});
      check("hold_pc", pc, prev_pc);
    end
    if (imem_req_valid) check("req_addr", imem_req_addr, model_pc);
    if (ins_valid) begin
      check("ins_pc", pc, model_pc);
      check("ins_word", {32'b0, ins}, {32'b0, mem_word(model_pc)});
    end
    check("req_ins_excl", {63'b0, imem_req_valid & ins_valid}, 64'd0);

    redirect_valid = frc ? 1'b1 : ($urandom_range(0, 99) < redir_pct);
    redirect_pc    = frc ? tgt : rand_tgt();
    imem_req_ready = frc ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
    ins_ready      = frc ? 1'b1 : ($urandom_range(0, 99) < insrdy_pct);
    dlv            = pend && (pend_cnt == 0);
    imem_resp_valid = dlv;
    imem_resp_data  = dlv ? mem_word(pend_addr) : $urandom;

    acc  = imem_req_valid && imem_req_ready;
    cons = ins_valid && ins_ready && !redirect_valid;
    if (dlv) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (acc) begin
      check("one_outstanding", {63'b0, pend}, 64'd0);
      pend      = 1'b1;
      pend_cnt  = $urandom_range(lat_lo, lat_hi) - 1;
      pend_addr = imem_req_addr;
      req_q.push_back(imem_req_addr);
      req_cyc.push_back(cycle);
    end

    hold_chk = ins_valid && !ins_ready && !redirect_valid;
    prev_ins = ins;
    prev_pc  = pc;
    if (redirect_valid) model_pc = redirect_pc & ~64'h3;
    else if (cons) begin
      model_pc = model_pc + 64'd4;
      n_cons++;
    end
    last_acc = acc;
    @(negedge clk);
    cycle++;
  endtask

  task automatic model_reset();
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    ins_ready       = 1'b0;
    pend            = 1'b0;
    pend_cnt        = 0;
    model_pc        = ifu_pkg::RESET_PC;
    hold_chk        = 1'b0;
    last_acc        = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_valid"}, {63'b0, imem_req_valid}, 64'd0);
    check({tag, "_ins_valid"}, {63'b0, ins_valid}, 64'd0);
    check({tag, "_pc"}, pc, ifu_pkg::RESET_PC);
    check({tag, "_ins"}, {32'b0, ins}, {32'b0, ifu_pkg::NOP});
  endtask

  task automatic wait_new_req(input string tag, input int n, input logic [63:0] exp);
    int k = 0;
    while (req_q.size() <= n && k < 40) begin
      cyc(1'b0, '0);
      k++;
    end
    if (req_q.size() > n) check(tag, req_q[n], exp);
    else check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic wait_ins_valid(input string tag);
    int k = 0;
    while (!ins_valid && k < 40) begin
      cyc(1'b0, '0);
      k++;
    end
    check(tag, {63'b0, ins_valid}, 64'd1);
  endtask

  task automatic wait_acc(input string tag);
    int k = 0;
    while (!last_acc && k < 40) begin
      cyc(1'b0, '0);
      k++;
    end
    check(tag, {63'b0, last_acc}, 64'd1);
  endtask

  initial begin
    int n, k, cons0;
    logic [31:0] ins0;
    logic [63:0] pc0;

    cycle = 0;
    n_cons = 0;
    rdy_pct = 100; insrdy_pct = 100; redir_pct = 0; lat_lo = 1; lat_hi = 1;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    // Back-to-back fetches with zero-wait memory.
    k = 0;
    while (req_q.size() < 3 && k < 30) begin
      cyc(1'b0, '0);
      k++;
    end
    check("seq_req_count", 64'(req_q.size()), 64'd3);
    if (req_q.size() >= 3) begin
      check("seq_addr0", req_q[0], 64'h8000_0000);
      check("seq_addr1", req_q[1], 64'h8000_0004);
      check("seq_addr2", req_q[2], 64'h8000_0008);
      check("seq_gap01", 64'(req_cyc[1] - req_cyc[0]), 64'd3);
      check("seq_gap12", 64'(req_cyc[2] - req_cyc[1]), 64'd3);
    end

    // Decoder stalls for 5 cycles while an instruction is held.
    insrdy_pct = 0;
    wait_ins_valid("stall_wait");
    ins0 = ins;
    pc0  = pc;
    n    = req_q.size();
    repeat (5) cyc(1'b0, '0);
    check("stall_valid", {63'b0, ins_valid}, 64'd1);
    check("stall_ins", {32'b0, ins}, {32'b0, ins0});
    check("stall_pc", pc, pc0);
    check("stall_no_req", 64'(req_q.size()), 64'(n));
    insrdy_pct = 100;

    // Redirect in WAIT; the response lands two cycles later and is dropped.
    lat_lo = 3; lat_hi = 3;
    wait_acc("wait_redir_acc");
    cyc(1'b1, 64'h8000_0102);
    n = req_q.size();
    wait_new_req("wait_redir_target", n, 64'h8000_0100);

    // Redirect in HOLD with ins_ready high: the held word is not consumed.
    lat_lo = 1; lat_hi = 2;
    insrdy_pct = 0;
    wait_ins_valid("hold_redir_wait");
    cons0 = n_cons;
    cyc(1'b1, 64'h8000_0200);
    check("hold_redir_valid_low", {63'b0, ins_valid}, 64'd0);
    check("hold_redir_pc", pc, 64'h8000_0200);
    insrdy_pct = 100;
    n = req_q.size();
    wait_new_req("hold_redir_target", n, 64'h8000_0200);
    check("hold_redir_not_consumed", 64'(n_cons - cons0), 64'd0);

    // Redirect coincident with the request handshake: DROP then refetch.
    lat_lo = 2; lat_hi = 2;
    k = 0;
    while (!imem_req_valid && k < 40) begin
      cyc(1'b0, '0);
      k++;
    end
    cyc(1'b1, 64'h8000_0300);
    n = req_q.size();
    wait_new_req("req_redir_target", n, 64'h8000_0300);

    // pc wraps modulo 2^64 after the top word.
    lat_lo = 1; lat_hi = 1;
    cyc(1'b1, 64'hffff_ffff_ffff_ffff);
    n = req_q.size();
    wait_new_req("wrap_top", n, 64'hffff_ffff_ffff_fffc);
    wait_new_req("wrap_zero", n + 1, 64'h0);

    // Asynchronous reset while a request is in flight.
    lat_lo = 4; lat_hi = 4;
    wait_acc("rst_wait_acc");
    cyc(1'b0, '0);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_vals("rst_hold");
    rst_n = 1'b1;
    n = req_q.size();
    wait_new_req("rst_restart", n, ifu_pkg::RESET_PC);

    // Randomised traffic against the model.
    rdy_pct = 80; insrdy_pct = 70; redir_pct = 8; lat_lo = 1; lat_hi = 3;
    cons0 = n_cons;
    repeat (3000) cyc(1'b0, '0);
    check("random_progress", {63'b0, (n_cons - cons0) > 100}, 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
